// File: rtl/gtxe2_comm_qpll_refclk_ctrl.sv
// QPLL reference-clock select and reset sequencer.
// The select only moves while QPLLRESET is asserted. After reset release and a
// settle period, it waits for a filtered lock. It then reports lock, timeout
// and lock loss.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_ASSERT_RST | QPLLRESET held high, counting down RESET_CYCLES
// ST_SETTLE     | QPLLRESET released, waiting SETTLE_CYCLES before sampling lock
// ST_WAIT_LOCK  | filtering synchronized lock, bounded by LOCK_TIMEOUT
// ST_LOCKED     | lock qualified; accepts requests, watches for lock loss
// ST_FAILED     | lock timed out; accepts requests, no automatic retry
module gtxe2_comm_qpll_refclk_ctrl #(
    parameter logic [2:0] DEFAULT_SEL   = 3'b001,
    parameter int         RESET_CYCLES  = 16,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         LOCK_FILTER   = 8,
    parameter int         LOCK_TIMEOUT  = 4096,
    parameter int         CNT_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_sel,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       qplllock,
    output logic [2:0] qpllrefclksel,
    output logic       qpllreset,
    output logic       locked,
    output logic       busy,
    output logic       done,
    output logic       timeout_err,
    output logic       req_err,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        ST_ASSERT_RST,
        ST_SETTLE,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAILED
    } state_t;

    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam logic [CNT_WIDTH-1:0] RST_LOAD    = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LOAD     = CNT_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [FILT_W-1:0]    FILT_MAX    = FILT_W'(LOCK_FILTER);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [FILT_W-1:0]    filt_q, filt_d, filt_nxt;
    logic                 lock_m, lock_s;
    logic [2:0]           sel_d;
    logic                 timeout_d, done_d, req_err_d;
    logic [7:0]           loss_d;
    logic                 accept;

    // two-flop synchronizer for the asynchronous QPLL lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= qplllock;
            lock_s <= lock_m;
        end
    end

    // consecutive-lock filter value for this cycle, saturating at LOCK_FILTER
    always_comb begin
        filt_nxt = '0;
        if (lock_s) begin
            filt_nxt = (filt_q == FILT_MAX) ? filt_q : filt_q + FILT_W'(1);
        end
    end

    // next-state, counter and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        filt_d    = filt_nxt;
        sel_d     = qpllrefclksel;
        timeout_d = timeout_err;
        done_d    = 1'b0;
        req_err_d = 1'b0;
        loss_d    = loss_cnt;
        accept    = req_valid & req_ready;

        case (state_q)
            ST_ASSERT_RST: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = TO_LOAD;
                    filt_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // lock takes priority over a timeout in the same cycle
                if (filt_nxt == FILT_MAX) begin
                    state_d = ST_LOCKED;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d   = ST_FAILED;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_LOCKED: begin
                if (!lock_s) begin
                    state_d = ST_ASSERT_RST;
                    cnt_d   = RST_LOAD;
                    loss_d  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                end
            end
            ST_FAILED: begin
                state_d = ST_FAILED;
            end
            default: begin
                state_d = ST_ASSERT_RST;
                cnt_d   = RST_LOAD;
            end
        endcase

        // a valid request overrides a coincident lock loss; the loss is still counted
        if (accept) begin
            if (req_sel == 3'b000) begin
                req_err_d = 1'b1;
            end else begin
                sel_d     = req_sel;
                state_d   = ST_ASSERT_RST;
                cnt_d     = RST_LOAD;
                timeout_d = 1'b0;
            end
        end
    end

    // state, counters and all outputs registered together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ASSERT_RST;
            cnt_q         <= RST_LOAD;
            filt_q        <= '0;
            qpllrefclksel <= DEFAULT_SEL;
            qpllreset     <= 1'b1;
            busy          <= 1'b1;
            req_ready     <= 1'b0;
            locked        <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            req_err       <= 1'b0;
            loss_cnt      <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            filt_q        <= filt_d;
            qpllrefclksel <= sel_d;
            qpllreset     <= (state_d == ST_ASSERT_RST);
            busy          <= (state_d == ST_ASSERT_RST) || (state_d == ST_SETTLE) ||
                             (state_d == ST_WAIT_LOCK);
            req_ready     <= (state_d == ST_LOCKED) || (state_d == ST_FAILED);
            locked        <= (state_d == ST_LOCKED);
            done          <= done_d;
            timeout_err   <= timeout_d;
            req_err       <= req_err_d;
            loss_cnt      <= loss_d;
        end
    end

endmodule
